// File: rtl/arb_merge2_1_pkg.sv
// Shared definitions for the arb_merge2_1 merge stage and its output buffer.
package arb_merge2_1_pkg;

  typedef logic [0:0] state_t;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  localparam int unsigned BUF_DEPTH = 2;

  // Buffer entry layout: {src, last, data}
  function automatic int unsigned entry_width(input int unsigned data_width);
    return data_width + 2;
  endfunction

endpackage

// File: rtl/arb_merge2_1_if.sv
// Two-source / one-sink handshake bundle for the 2:1 merge stage.
interface arb_merge2_1_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    i_en;
  logic [1:0]              i_valid;
  logic [2*DATA_WIDTH-1:0] i_data_bus;
  logic [1:0]              i_last;
  logic [1:0]              o_ready;
  logic                    o_valid;
  logic [DATA_WIDTH-1:0]   o_data_bus;
  logic                    o_src;
  logic                    o_last;
  logic                    i_ready;

  modport master (
    output i_en, i_valid, i_data_bus, i_last, i_ready,
    input  o_ready, o_valid, o_data_bus, o_src, o_last
  );

  modport slave (
    input  i_en, i_valid, i_data_bus, i_last, i_ready,
    output o_ready, o_valid, o_data_bus, o_src, o_last
  );
endinterface

// File: rtl/arb_merge2_1_fifo_buf2.sv
// 2-entry registered FIFO; head reads as zero while empty.
module fifo_buf2
  import arb_merge2_1_pkg::*;
#(
  parameter int unsigned WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [1:0]       o_count,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_head
);
  logic [WIDTH-1:0] r_mem [BUF_DEPTH];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push & (r_count < 2'(BUF_DEPTH));
  assign w_pop  = i_pop & (r_count != 2'd0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_valid = (r_count != 2'd0);
  assign o_head  = o_valid ? r_mem[r_rptr] : '0;
endmodule

// File: rtl/arb_merge2_1.sv
// Packet-aware round-robin 2:1 merge with a registered 2-entry output buffer.
module arb_merge2_1
  import arb_merge2_1_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  arb_merge2_1_if.slave  bus
);
  localparam int unsigned EW = entry_width(DATA_WIDTH);

  state_t                r_state;
  logic                  r_rr_ptr;
  logic                  r_lock_src;

  logic [1:0]            w_count;
  logic                  w_space;
  logic                  w_fifo_valid;
  logic [EW-1:0]         w_head;
  logic [EW-1:0]         w_entry;
  logic [1:0]            w_gnt;
  logic [1:0]            w_ready;
  logic [1:0]            w_acc;
  logic                  w_acc_any;
  logic                  w_acc_ch;
  logic                  w_acc_last;
  logic [DATA_WIDTH-1:0] w_acc_data;
  logic                  w_pop;

  always_comb begin
    w_gnt = '0;
    if (r_state == LOCK) begin
      w_gnt = r_lock_src ? 2'b10 : 2'b01;
    end else begin
      case (bus.i_valid)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = r_rr_ptr ? 2'b10 : 2'b01;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  // Ready depends only on registered state, i_valid, i_en and rst_n; never on i_ready.
  assign w_space    = (w_count < 2'(BUF_DEPTH));
  assign w_ready    = w_gnt & {2{bus.i_en & w_space & rst_n}};
  assign w_acc      = bus.i_valid & w_ready;
  assign w_acc_any  = |w_acc;
  assign w_acc_ch   = w_acc[1];
  assign w_acc_last = bus.i_last[w_acc_ch];
  assign w_acc_data = w_acc_ch ? bus.i_data_bus[DATA_WIDTH +: DATA_WIDTH]
                               : bus.i_data_bus[DATA_WIDTH-1:0];
  assign w_entry    = {w_acc_ch, w_acc_last, w_acc_data};
  assign w_pop      = w_fifo_valid & bus.i_ready;

  fifo_buf2 #(.WIDTH(EW)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_acc_any),
    .i_din   (w_entry),
    .i_pop   (w_pop),
    .o_count (w_count),
    .o_valid (w_fifo_valid),
    .o_head  (w_head)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rr_ptr   <= 1'b0;
      r_lock_src <= 1'b0;
    end else if (w_acc_any) begin
      if (r_state == IDLE) begin
        if (w_acc_last) begin
          r_rr_ptr <= ~w_acc_ch;
        end else begin
          r_state    <= LOCK;
          r_lock_src <= w_acc_ch;
        end
      end else if (w_acc_last) begin
        r_state  <= IDLE;
        r_rr_ptr <= ~r_lock_src;
      end
    end
  end

  assign bus.o_ready    = w_ready;
  assign bus.o_valid    = w_fifo_valid;
  assign bus.o_src      = w_head[EW-1];
  assign bus.o_last     = w_head[EW-2];
  assign bus.o_data_bus = w_head[DATA_WIDTH-1:0];
endmodule
